// File: rtl/button_debouncer.sv
// Debounces an active-low push-button into a clean level plus press/release pulses.
// Define BUTTON_DEBOUNCE_LONG_PRESS_EN to build the long-press hold counter and long_pulse.
//
// state           | meaning
// ----------------+-------------------------------------------------
// ST_RELEASED     | button up, waiting for a synchronized press
// ST_PRESS_WAIT   | press seen, counting DB_CYCLES stable samples
// ST_PRESSED      | debounced press, waiting for a release sample
// ST_RELEASE_WAIT | release seen, counting DB_CYCLES stable samples
module button_debouncer #(
  parameter int CLK_F       = 24_000_000,
  parameter int DEBOUNCE_MS = 10,
  parameter int LONG_MS     = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic pressed,
  output logic button_db_n,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  localparam int DB_CYCLES = CLK_F / 1000 * DEBOUNCE_MS;
  localparam int CW        = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

  localparam logic [1:0] ST_RELEASED     = 2'd0;
  localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] ST_PRESSED      = 2'd2;
  localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

  if (DB_CYCLES < 2 || LONG_MS < 0) begin : g_bad_params
    $error("button_debouncer: DB_CYCLES must be at least 2 and LONG_MS non-negative");
  end

  logic          s1, s2, raw_p;
  logic [1:0]    state, state_nxt;
  logic [CW-1:0] ctr, ctr_nxt;
  logic          press_ev, release_ev, pressed_nxt;

  // Synchronizer resets to the released level so reset never fakes a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= button;
      s2 <= s1;
    end
  end

  assign raw_p = ~s2;

  always_comb begin
    state_nxt  = state;
    ctr_nxt    = ctr;
    press_ev   = 1'b0;
    release_ev = 1'b0;
    case (state)
      ST_RELEASED: begin
        if (raw_p) begin
          state_nxt = ST_PRESS_WAIT;
          ctr_nxt   = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (!raw_p) begin
          state_nxt = ST_RELEASED;
          ctr_nxt   = '0;
        end else if (ctr == DB_LAST) begin
          state_nxt = ST_PRESSED;
          ctr_nxt   = '0;
          press_ev  = 1'b1;
        end else begin
          ctr_nxt = ctr + CW'(1);
        end
      end
      ST_PRESSED: begin
        if (!raw_p) begin
          state_nxt = ST_RELEASE_WAIT;
          ctr_nxt   = '0;
        end
      end
      default: begin
        if (raw_p) begin
          state_nxt = ST_PRESSED;
          ctr_nxt   = '0;
        end else if (ctr == DB_LAST) begin
          state_nxt  = ST_RELEASED;
          ctr_nxt    = '0;
          release_ev = 1'b1;
        end else begin
          ctr_nxt = ctr + CW'(1);
        end
      end
    endcase
  end

  assign pressed_nxt = (state_nxt == ST_PRESSED) || (state_nxt == ST_RELEASE_WAIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_RELEASED;
      ctr           <= '0;
      pressed       <= 1'b0;
      button_db_n   <= 1'b1;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state         <= state_nxt;
      ctr           <= ctr_nxt;
      pressed       <= pressed_nxt;
      button_db_n   <= ~pressed_nxt;
      press_pulse   <= press_ev;
      release_pulse <= release_ev;
    end
  end

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
  localparam int LONG_CYCLES = CLK_F / 1000 * LONG_MS;
  localparam int HW          = $clog2(LONG_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_PRE  = HW'(LONG_CYCLES - 2);

  if (LONG_CYCLES <= DB_CYCLES) begin : g_bad_long
    $error("button_debouncer: LONG_CYCLES must exceed DB_CYCLES");
  end

  logic [HW-1:0] hold;

  // Saturation makes long_pulse fire once; it is suppressed on the release edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold       <= '0;
      long_pulse <= 1'b0;
    end else begin
      long_pulse <= 1'b0;
      if (press_ev) begin
        hold <= '0;
      end else if (state == ST_PRESSED || state == ST_RELEASE_WAIT) begin
        if (hold != HOLD_LAST) hold <= hold + HW'(1);
        long_pulse <= (hold == HOLD_PRE) && pressed_nxt;
      end
    end
  end
`else
  assign long_pulse = 1'b0;
`endif

endmodule

// File: doc/button_debouncer.md
# button_debouncer

Conditions the raw, active-low, bouncing push-button pin on the 24 MHz board clock into a clean debounced level plus single-cycle press/release event pulses. Sits directly upstream of the LED-counter test logic: its `button_db_n` output drives that stage's active-low `button` input in place of the raw pin. An optional long-press detector emits one extra pulse when the button is held.

## Interface
- `CLK_F`, default 24_000_000: clock frequency in Hz.
- `DEBOUNCE_MS`, default 10: required stable time in ms. `DB_CYCLES = CLK_F/1000*DEBOUNCE_MS`, which must be ≥ 2.
- `LONG_MS`, default 1000: hold time for a long press. `LONG_CYCLES = CLK_F/1000*LONG_MS`, which must be > `DB_CYCLES`.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `button` in 1: raw pin, active-low (0 = pressed), asynchronous to `clk`.
- `pressed` out 1: debounced level, 1 = pressed.
- `button_db_n` out 1: `~pressed`, for downstream active-low consumers.
- `press_pulse` out 1: one-cycle pulse on each debounced press.
- `release_pulse` out 1: one-cycle pulse on each debounced release.
- `long_pulse` out 1: one-cycle pulse when the hold reaches `LONG_CYCLES`. Constant 0 when the feature is compiled out.

## Operation
- Two-flop synchronizer `s1 -> s2` on `button`. `raw_p = ~s2`.
- Debounce counter width is `$clog2(DB_CYCLES)`. Hold counter width is `$clog2(LONG_CYCLES)`. All counters are unsigned and compare with equality only.
- FSM states and transitions:
  - RELEASED: if `raw_p`, go to PRESS_WAIT with ctr=0.
  - PRESS_WAIT:
    - if `!raw_p`, go to RELEASED with ctr=0 (bounce rejected, no pulse).
    - else if ctr==DB_CYCLES-1, go to PRESSED and assert `press_pulse`.
    - else ctr+1.
  - PRESSED: if `!raw_p`, go to RELEASE_WAIT with ctr=0.
  - RELEASE_WAIT:
    - if `raw_p`, go to PRESSED with ctr=0 (no pulse; hold counter keeps running).
    - else if ctr==DB_CYCLES-1, go to RELEASED and assert `release_pulse`.
    - else ctr+1.
- `pressed` = 1 in PRESSED and RELEASE_WAIT, else 0. All outputs are registered.
- Pulses last exactly one cycle and never overlap. Each press yields at most one `press_pulse`, one `long_pulse`, and one `release_pulse`.
- Hold counter:
  - cleared on entry to PRESSED from PRESS_WAIT;
  - increments in PRESSED/RELEASE_WAIT;
  - saturates at LONG_CYCLES-1.
- Reset values: state RELEASED, ctr=0, hold=0, `s1`=`s2`=1 (released, so no false press after reset), `pressed`=0, `button_db_n`=1, all pulses 0.
- Reset mid-operation aborts any wait or hold immediately and emits no pulses. A button still held after reset is re-debounced as a new press.

## Timing
- Let E0 be the first edge that samples `button`=0 into `s1`, with the pin stable low thereafter:
  - `s2`=0 after E1;
  - PRESS_WAIT after E2;
  - PRESSED, `pressed`=1 and `press_pulse`=1 after edge E(2+DB_CYCLES);
  - `press_pulse` returns to 0 one edge later.
- Release latency is symmetric: `release_pulse` and `pressed`=0 follow edge E(2+DB_CYCLES) after the first edge sampling `button`=1.
- Any contrary sample during a wait restarts the full DB_CYCLES window.
- `long_pulse` asserts on the edge where the hold counter reaches LONG_CYCLES-1, i.e. LONG_CYCLES-1 edges after `press_pulse` asserts, and only once per press. If release completes first, no `long_pulse` is emitted.
- If the long threshold is hit while in RELEASE_WAIT, `long_pulse` still fires.

## Configuration
- `BUTTON_DEBOUNCE_LONG_PRESS_EN` defined: the hold counter and `long_pulse` logic are built as specified above.
- Undefined: no hold counter is instantiated, `long_pulse` is tied to 0, `LONG_MS` is ignored, and all other behaviour is identical.

## Test plan
All scenarios use `CLK_F=1000`, `DEBOUNCE_MS=5`, `LONG_MS=20` (DB_CYCLES=5, LONG_CYCLES=20).

- Reset, then hold `button`=1 for 50 cycles: `pressed`=0, `button_db_n`=1, and no pulses.
- Drive `button`=0 at E0 and hold: `press_pulse` is high exactly once, after E7. `pressed`=1 from E7 onward.
- Bounce: `button` 0 for 3 cycles, 1 for 1, then 0 held: no pulse until 5 uninterrupted cycles have elapsed after the final synchronized 0. Exactly one `press_pulse`.
- Press then release, with a 2-cycle release glitch mid-hold: the glitch produces no `release_pulse` and `pressed` stays 1. The real release gives one `release_pulse` 7 edges after the first 1-sample.
- Macro defined, hold for 40 cycles: exactly one `long_pulse`, 19 edges after `press_pulse`. Macro undefined: `long_pulse` stays 0 throughout.
- Assert `rst` in PRESS_WAIT, and separately in PRESSED: outputs return to their reset values on the next edge with no pulses. A held button re-presses with `press_pulse` at 7 edges after reset release.
